fsm_q3c_seq_driver: RTL and testbench

Stimulus-side counterpart of the 2014_q3c state machine (3-bit state y, serial input x, Moore output z). It holds a shadow copy of that FSM's state. On request it emits the shortest serial x bit sequence that steers the FSM to a requested target state. One x bit is sent per accepted beat, and completion or error is reported on a response strobe. It sits between a test or sequence controller and the q3c FSM instance.

---
 rtl/fsm_q3c_seq_driver.sv | 177 +++++++++++++++++
 tb/tb_fsm_q3c_seq_driver.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_q3c_seq_driver.sv
// Sequence driver for the 2014_q3c FSM: keeps a shadow of its state and emits
// the shortest serial x path to a requested target. Optional z cross-check: FSM_Q3C_ZCHECK_EN.
module fsm_q3c_seq_driver #(
  parameter int MAX_STEPS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [2:0] req_target,
  output logic       req_ready,
  output logic       x,
  output logic       x_valid,
  input  logic       x_ready,
  output logic       resp_valid,
  output logic       resp_err,
  output logic [2:0] resp_steps,
  output logic [2:0] shadow_state,
  output logic       z_exp
`ifdef FSM_Q3C_ZCHECK_EN
  ,
  input  logic       z_obs,
  output logic       z_mismatch
`endif
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_STEPS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_RESP
  } ctrl_e;

  function automatic logic [2:0] next_state(input logic [2:0] s, input logic b);
    logic [2:0] n;
    case (s)
      3'b000:  n = b ? 3'b001 : 3'b000;
      3'b001:  n = b ? 3'b100 : 3'b001;
      3'b010:  n = b ? 3'b001 : 3'b010;
      3'b011:  n = b ? 3'b010 : 3'b001;
      3'b100:  n = b ? 3'b100 : 3'b011;
      default: n = s;
    endcase
    return n;
  endfunction

  // First bit of the shortest path from s to t.
  function automatic logic hop(input logic [2:0] s, input logic [2:0] t);
    logic b;
    b = 1'b1;
    if (s == 3'b100) b = 1'b0;
    else if (s == 3'b011 && (t == 3'b001 || t == 3'b100)) b = 1'b0;
    return b;
  endfunction

  ctrl_e      ctrl_q, ctrl_d;
  logic [2:0] shadow_q, shadow_d;
  logic [2:0] step_cnt_q, step_cnt_d;
  logic [2:0] target_q, target_d;
  logic       x_q, x_d;
  logic       err_q, err_d;
  logic [2:0] shadow_nx;
  logic       accept_req;
  logic       zerr;

  assign accept_req = (ctrl_q == ST_IDLE) && req_valid;
  assign shadow_nx  = next_state(shadow_q, x_q);

  always_comb begin
    ctrl_d     = ctrl_q;
    shadow_d   = shadow_q;
    step_cnt_d = step_cnt_q;
    target_d   = target_q;
    x_d        = x_q;
    err_d      = err_q;
    case (ctrl_q)
      ST_IDLE: begin
        if (req_valid) begin
          step_cnt_d = 3'd0;
          target_d   = req_target;
          err_d      = 1'b0;
          // 000 has no incoming edges, so it is only reachable trivially
          if (req_target > 3'b100 || (req_target == 3'b000 && shadow_q != 3'b000)) begin
            err_d  = 1'b1;
            ctrl_d = ST_RESP;
          end else if (req_target == shadow_q) begin
            ctrl_d = ST_RESP;
          end else begin
            ctrl_d = ST_DRIVE;
            x_d    = hop(shadow_q, req_target);
          end
        end
      end
      ST_DRIVE: begin
        if (x_ready) begin
          shadow_d   = shadow_nx;
          step_cnt_d = step_cnt_q + 3'd1;
          if (shadow_nx == target_q) begin
            ctrl_d = ST_RESP;
            x_d    = 1'b0;
          end else if (step_cnt_q + 3'd1 == MAX_CNT) begin
            err_d  = 1'b1;
            ctrl_d = ST_RESP;
            x_d    = 1'b0;
          end else begin
            x_d = hop(shadow_nx, target_q);
          end
        end
      end
      ST_RESP: ctrl_d = ST_IDLE;
      default: ctrl_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= ST_IDLE;
      shadow_q   <= 3'b000;
      step_cnt_q <= 3'd0;
      target_q   <= 3'b000;
      x_q        <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      shadow_q   <= shadow_d;
      step_cnt_q <= step_cnt_d;
      target_q   <= target_d;
      x_q        <= x_d;
      err_q      <= err_d;
    end
  end

`ifdef FSM_Q3C_ZCHECK_EN
  logic beat_q, beat_d;
  logic zmis_q, zmis_d;
  logic req_mis_q, req_mis_d;
  logic mis_now;

  // z_obs reflects the beat accepted on the previous edge
  assign mis_now = beat_q && (z_obs != z_exp);

  always_comb begin
    beat_d    = (ctrl_q == ST_DRIVE) && x_ready;
    zmis_d    = zmis_q | mis_now;
    req_mis_d = req_mis_q;
    if (accept_req) req_mis_d = 1'b0;
    else if (mis_now) req_mis_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_q    <= 1'b0;
      zmis_q    <= 1'b0;
      req_mis_q <= 1'b0;
    end else begin
      beat_q    <= beat_d;
      zmis_q    <= zmis_d;
      req_mis_q <= req_mis_d;
    end
  end

  assign zerr       = req_mis_q | mis_now;
  assign z_mismatch = zmis_q;
`else
  assign zerr = 1'b0;
`endif

  assign req_ready    = (ctrl_q == ST_IDLE);
  assign x_valid      = (ctrl_q == ST_DRIVE);
  assign x            = x_q;
  assign resp_valid   = (ctrl_q == ST_RESP);
  assign resp_err     = resp_valid & (err_q | zerr);
  assign resp_steps   = resp_valid ? step_cnt_q : 3'd0;
  assign shadow_state = shadow_q;
  assign z_exp        = (shadow_q == 3'b011) || (shadow_q == 3'b100);

endmodule

// File: tb/tb_fsm_q3c_seq_driver.sv
// Scoreboard bench for fsm_q3c_seq_driver: random requests against a
// shortest-path model of the q3c transition graph, plus a MAX_STEPS=2 instance.
module tb_fsm_q3c_seq_driver;

  localparam int MAXS = 4;
  localparam int N0[5] = '{0, 1, 2, 1, 3};
  localparam int N1[5] = '{1, 4, 1, 2, 4};

  typedef struct {
    logic       err;
    int         steps;
    logic [2:0] shadow;
    logic       z;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, req_valid, x_ready;
  logic [2:0] req_target;
  logic       req_ready, x, x_valid, resp_valid, resp_err, z_exp;
  logic [2:0] resp_steps, shadow_state;

  logic       reset2, req_valid2, x_ready2;
  logic [2:0] req_target2;
  logic       req_ready2, x2, x_valid2, resp_valid2, resp_err2, z_exp2;
  logic [2:0] resp_steps2, shadow_state2;

`ifdef FSM_Q3C_ZCHECK_EN
  logic z_mis, z_mis2;
`endif

  fsm_q3c_seq_driver #(.MAX_STEPS(MAXS)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_target(req_target),
    .req_ready(req_ready), .x(x), .x_valid(x_valid), .x_ready(x_ready),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_steps(resp_steps),
    .shadow_state(shadow_state), .z_exp(z_exp)
`ifdef FSM_Q3C_ZCHECK_EN
    , .z_obs(z_exp), .z_mismatch(z_mis)
`endif
  );

  fsm_q3c_seq_driver #(.MAX_STEPS(2)) dut2 (
    .clk(clk), .reset(reset2), .req_valid(req_valid2), .req_target(req_target2),
    .req_ready(req_ready2), .x(x2), .x_valid(x_valid2), .x_ready(x_ready2),
    .resp_valid(resp_valid2), .resp_err(resp_err2), .resp_steps(resp_steps2),
    .shadow_state(shadow_state2), .z_exp(z_exp2)
`ifdef FSM_Q3C_ZCHECK_EN
    , .z_obs(z_exp2), .z_mismatch(z_mis2)
`endif
  );

  int   n_cmp = 0;
  int   n_fail = 0;
  int   resp_cnt = 0;
  int   rdy_mode = 2;
  bit   mon_en = 1'b0;
  bit   done2 = 1'b0;
  bit   beat_q[$];
  exp_t exp_q[$];
  logic [2:0] model_s;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  // Shortest path over the transition graph by distance relaxation.
  task automatic model_req(input logic [2:0] s, input logic [2:0] t, input int maxs,
                           output logic err, output int steps, output logic [2:0] fin,
                           output bit bits[8]);
    int d[5];
    int cur, m;
    bits = '{default: 1'b0};
    steps = 0;
    fin = s;
    err = 1'b0;
    if (t > 3'd4 || (t == 3'd0 && s != 3'd0)) begin
      err = 1'b1;
      return;
    end
    for (int i = 0; i < 5; i++) d[i] = (i == int'(t)) ? 0 : 99;
    repeat (5) begin
      for (int i = 0; i < 5; i++) begin
        m = ((d[N0[i]] < d[N1[i]]) ? d[N0[i]] : d[N1[i]]) + 1;
        if (m < d[i]) d[i] = m;
      end
    end
    cur = int'(s);
    while (cur != int'(t) && steps < maxs) begin
      bits[steps] = (d[N1[cur]] < d[N0[cur]]);
      cur = bits[steps] ? N1[cur] : N0[cur];
      steps++;
    end
    fin = 3'(cur);
    err = (cur != int'(t));
  endtask

  initial begin
    x_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: x_ready = 1'b0;
        1: x_ready = 1'b1;
        default: x_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (x_valid) begin
        if (beat_q.size() == 0) fail_now("unexpected_beat");
        else begin
          chk("x_bit", int'(x), int'(beat_q[0]));
          if (x_ready) void'(beat_q.pop_front());
        end
      end
      if (resp_valid) begin
        if (exp_q.size() == 0) fail_now("unexpected_resp");
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("resp_err", int'(resp_err), int'(e.err));
          chk("resp_steps", int'(resp_steps), e.steps);
          chk("resp_shadow", int'(shadow_state), int'(e.shadow));
          chk("resp_z_exp", int'(z_exp), int'(e.z));
          chk("beats_left", beat_q.size(), 0);
        end
        resp_cnt++;
      end else begin
        chk("err_idle", int'(resp_err), 0);
        chk("steps_idle", int'(resp_steps), 0);
      end
    end
  end

  task automatic do_req(input logic [2:0] t);
    int   waitc, r0, steps;
    logic err;
    logic [2:0] fin;
    bit   bits[8];
    exp_t e;
    @(negedge clk);
    waitc = 0;
    while (!req_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (!req_ready) begin
      fail_now("req_ready_timeout");
      return;
    end
    chk("shadow_at_req", int'(shadow_state), int'(model_s));
    model_req(model_s, t, MAXS, err, steps, fin, bits);
    for (int i = 0; i < steps; i++) beat_q.push_back(bits[i]);
    e.err = err;
    e.steps = steps;
    e.shadow = fin;
    e.z = (fin == 3'd3 || fin == 3'd4);
    exp_q.push_back(e);
    model_s = fin;
    r0 = resp_cnt;
    req_valid = 1'b1;
    req_target = t;
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_target = 3'($urandom);
    @(negedge clk);
    chk("req_ready_busy", int'(req_ready), 0);
    waitc = 0;
    while (resp_cnt == r0 && waitc < 100) begin
      if (x_valid && $urandom_range(0, 3) == 0) begin
        req_valid = 1'b1;
        req_target = 3'($urandom);
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      waitc++;
    end
    if (resp_cnt == r0) fail_now("resp_timeout");
  endtask

  initial begin
    logic [2:0] dir_t[8] = '{3'd4, 3'd2, 3'd2, 3'd6, 3'd1, 3'd0, 3'd3, 3'd4};
    int waitc;
    reset = 1'b1;
    req_valid = 1'b0;
    req_target = 3'd0;
    model_s = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", int'(req_ready), 1);
    chk("rst_x_valid", int'(x_valid), 0);
    chk("rst_x", int'(x), 0);
    chk("rst_resp_valid", int'(resp_valid), 0);
    chk("rst_resp_err", int'(resp_err), 0);
    chk("rst_resp_steps", int'(resp_steps), 0);
    chk("rst_shadow", int'(shadow_state), 0);
    chk("rst_z_exp", int'(z_exp), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    mon_en = 1'b1;

    rdy_mode = 1;
    for (int i = 0; i < 8; i++) do_req(dir_t[i]);
    rdy_mode = 2;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) < 8) do_req(3'($urandom_range(0, 4)));
      else do_req(3'($urandom_range(5, 7)));
    end

    // Reset while a request is stalled in DRIVE
    @(negedge clk);
    mon_en = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    rdy_mode = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_target = 3'd2;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_x_valid", int'(x_valid), 1);
      chk("stall_x", int'(x), 1);
    end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_x_valid", int'(x_valid), 0);
    chk("midrst_shadow", int'(shadow_state), 0);
    repeat (5) begin
      @(negedge clk);
      chk("midrst_no_resp", int'(resp_valid), 0);
    end
    beat_q.delete();
    exp_q.delete();
    model_s = 3'd0;
    rdy_mode = 2;
    mon_en = 1'b1;
    do_req(3'd2);
    do_req(3'd7);
    do_req(3'd0);

    waitc = 0;
    while (!done2 && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    if (!done2) fail_now("dut2_timeout");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // MAX_STEPS=2 instance: 000 -> 011 needs 3 beats, so it must abort after 2.
  initial begin
    int nb, waitc;
    reset2 = 1'b1;
    req_valid2 = 1'b0;
    req_target2 = 3'd0;
    x_ready2 = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset2 = 1'b0;
    @(negedge clk);
    req_valid2 = 1'b1;
    req_target2 = 3'd3;
    @(posedge clk);
    #1 req_valid2 = 1'b0;
    nb = 0;
    waitc = 0;
    while (waitc < 20) begin
      @(negedge clk);
      if (resp_valid2) break;
      if (x_valid2) begin
        chk("dut2_x", int'(x2), 1);
        nb++;
      end
      waitc++;
    end
    if (!resp_valid2) fail_now("dut2_resp_timeout");
    else begin
      chk("dut2_err", int'(resp_err2), 1);
      chk("dut2_steps", int'(resp_steps2), 2);
      chk("dut2_shadow", int'(shadow_state2), 4);
      chk("dut2_beats", nb, 2);
    end
    done2 = 1'b1;
  end

endmodule
